dct_mac_unit_p: RTL

Parametrised multiply-accumulate unit for the fdct_zigzag DCT datapath. It is the generalised successor of the fixed-width macu inside each dct_unit.
- Accumulates TAPS signed sample×coefficient products per block.
- Scales the sum by FRAC_SHIFT with selectable rounding, then saturates to RES_W.
- Presents the result on a valid/ready output register.
- Instantiated once per DCT unit; replaces hard-wired result[] registers.

---
 rtl/dct_mac_pkg.sv | 36 +++
 rtl/dct_mac_scale_sat.sv | 39 +++
 rtl/dct_mac_unit_p.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dct_mac_pkg.sv
// Shared definitions for the DCT multiply-accumulate unit and its scaler.
package dct_mac_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Largest value representable in a signed field of width w.
  function automatic longint res_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic longint res_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Half an output LSB after a right shift by frac_shift.
  function automatic longint round_const(input int frac_shift);
    return longint'(1) << (frac_shift - 1);
  endfunction

  localparam longint RES_MAX     = res_max(12);
  localparam longint RES_MIN     = res_min(12);
  localparam longint ROUND_CONST = round_const(8);

endpackage

// File: rtl/dct_mac_scale_sat.sv
// Combinational scale/round/saturate stage: acc -> signed RES_W result.
module dct_mac_scale_sat
  import dct_mac_pkg::*;
#(
  parameter int ACC_W      = 24,
  parameter int RES_W      = 12,
  parameter int FRAC_SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    rnd_mode,
  output logic signed [RES_W-1:0] result,
  output logic                    sat
);

  // One extra bit so adding the rounding constant cannot wrap.
  localparam int T_W = ACC_W + 1;
  localparam logic signed [T_W-1:0] K_ROUND = T_W'(round_const(FRAC_SHIFT));
  localparam logic signed [T_W-1:0] S_MAX   = T_W'(res_max(RES_W));
  localparam logic signed [T_W-1:0] S_MIN   = T_W'(res_min(RES_W));

  logic signed [T_W-1:0] t;
  logic signed [T_W-1:0] s;

  // Round, arithmetic shift, then clip to the result range.
  always_comb begin
    t      = T_W'(acc) + ((rnd_mode_e'(rnd_mode) == RND_HALF_UP) ? K_ROUND : '0);
    s      = t >>> FRAC_SHIFT;
    result = s[RES_W-1:0];
    sat    = 1'b0;
    if (s > S_MAX) begin
      result = S_MAX[RES_W-1:0];
      sat    = 1'b1;
    end else if (s < S_MIN) begin
      result = S_MIN[RES_W-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/dct_mac_unit_p.sv
// Parametrised MAC: TAPS products per block, scaled and saturated result
// presented on a valid/ready output register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high and ena is high. in_ready never depends on in_valid; out_valid,
// once high, stays high with result/sat stable until out_ready is seen.
module dct_mac_unit_p
  import dct_mac_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 12,
  parameter int TAPS       = 8,
  parameter int ACC_W      = 24,
  parameter int RES_W      = 12,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     clr,
  input  logic                     rnd_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] din,
  input  logic signed [COEF_W-1:0] coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RES_W-1:0]  result,
  output logic                     sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int TAP_W  = clog2(TAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  if (ACC_W < DATA_W + COEF_W + clog2(TAPS)) begin : g_acc_w_check
    $error("dct_mac_unit_p: ACC_W too small for DATA_W+COEF_W+clog2(TAPS)");
  end
  if (TAPS < 2) begin : g_taps_check
    $error("dct_mac_unit_p: TAPS must be at least 2");
  end
  if (FRAC_SHIFT < 1) begin : g_shift_check
    $error("dct_mac_unit_p: FRAC_SHIFT must be at least 1");
  end

  logic                     hold;
  logic                     accept;
  logic                     a_fire;
  logic                     load;
  logic [TAP_W-1:0]         tap_cnt;
  logic signed [PROD_W-1:0] mul;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld;
  logic                     prod_first;
  logic                     prod_last;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [RES_W-1:0]  res_next;
  logic                     sat_next;

  // A held result blocks new input; clr drops whatever is offered this cycle.
  assign hold     = out_valid & ~out_ready;
  assign in_ready = ena & ~rst & ~hold & ~clr;
  assign accept   = in_valid & in_ready;
  assign mul      = din * coef;

  // The last product of a block may not advance while the previous result is held.
  assign a_fire   = prod_vld & ~(prod_last & hold);
  assign load     = a_fire & prod_last;
  assign acc_next = (prod_first ? '0 : acc) + ACC_W'(prod_q);

  dct_mac_scale_sat #(
    .ACC_W      (ACC_W),
    .RES_W      (RES_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_scale_sat (
    .acc      (acc_next),
    .rnd_mode (rnd_mode),
    .result   (res_next),
    .sat      (sat_next)
  );

  // Stage M: register the product and its block-position tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt    <= '0;
      prod_q     <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        tap_cnt  <= '0;
        prod_vld <= 1'b0;
      end else if (accept) begin
        prod_q     <= mul;
        prod_vld   <= 1'b1;
        prod_first <= (tap_cnt == '0);
        prod_last  <= (tap_cnt == LAST_TAP);
        tap_cnt    <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
      end else if (a_fire) begin
        prod_vld <= 1'b0;
      end
    end
  end

  // Stage A: accumulate; the first product of a block restarts the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (ena) begin
      if (clr) begin
        acc <= '0;
      end else if (a_fire) begin
        acc <= acc_next;
      end
    end
  end

  // Output register: load on the last product, otherwise drain on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
    end else if (ena) begin
      if (load && !clr) begin
        out_valid <= 1'b1;
        result    <= res_next;
        sat       <= sat_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
